// File: rtl/smaesh_arb_pkg.sv
// Shared constants for the smaesh stream arbiter: FSM encoding and default stream masks.
package smaesh_arb_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] StIdle  = 2'd0;
    localparam logic [ST_W-1:0] StStart = 2'd1;
    localparam logic [ST_W-1:0] StBusy  = 2'd2;

    // Default layout: 0 = seed, 1 = key, 2 = data.
    localparam logic [2:0] DEF_NEED_SEED_MASK = 3'b110;
    localparam logic [2:0] DEF_READY_PULSE    = 3'b001;

endpackage

// File: rtl/smaesh_arb_prio_sel.sv
// Combinational winner select: lowest-index boosted stream, else lowest-index eligible stream.
module smaesh_arb_prio_sel #(
    parameter int unsigned NCH = 3,
    parameter int unsigned IW  = 2
) (
    input  logic [NCH-1:0] eligible,
    input  logic [NCH-1:0] boosted,
    output logic [NCH-1:0] grant_oh,
    output logic [IW-1:0]  grant_idx,
    output logic           grant_any
);

    logic [NCH-1:0] pick;

    assign pick      = (|boosted) ? boosted : eligible;
    assign grant_any = |eligible;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        // Walk downwards so the lowest set index is the last one written.
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/smaesh_stream_arbiter.sv
// Registered fixed-priority arbiter with aging, seed gating and per-stream ready modes,
// handing one of NCH input streams to its processing unit at a time.
module smaesh_stream_arbiter
    import smaesh_arb_pkg::*;
#(
    parameter int unsigned    NCH            = 3,
    parameter logic [NCH-1:0] NEED_SEED_MASK = NCH'(DEF_NEED_SEED_MASK),
    parameter logic [NCH-1:0] READY_PULSE    = NCH'(DEF_READY_PULSE),
    parameter int unsigned    AGE_MAX        = 4,
    parameter int unsigned    AGE_W          = 3,
    parameter int unsigned    START_TO       = 15,
    parameter int unsigned    TO_W           = 4,
    parameter int unsigned    IW             = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] in_valid,
    output logic [NCH-1:0] in_ready,
    input  logic [NCH-1:0] unit_in_ready,
    input  logic [NCH-1:0] unit_busy,
    input  logic           prng_seeded,
    output logic [NCH-1:0] unit_start,
    output logic [NCH-1:0] unit_valid,
    output logic [IW-1:0]  owner_idx,
    output logic           arb_busy,
    output logic           err_timeout
);

    localparam logic [AGE_W-1:0] AGE_SAT = {AGE_W{1'b1}};

    logic [ST_W-1:0]  state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [AGE_W-1:0] age_q [NCH];
    logic [AGE_W-1:0] age_d [NCH];
    logic [NCH-1:0]   prev_busy_q;
    logic             start_q, start_d;
    logic             err_q, err_d;

    logic [NCH-1:0] eligible, boosted, win_oh, owner_oh;
    logic [IW-1:0]  win_idx;
    logic           win_any, owner_busy;

    assign eligible = in_valid & (~NEED_SEED_MASK | {NCH{prng_seeded}});

    always_comb begin
        boosted  = '0;
        owner_oh = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            boosted[i]  = eligible[i] && (age_q[i] >= AGE_W'(AGE_MAX));
            owner_oh[i] = (owner_q == IW'(i));
        end
    end

    assign owner_busy = |(unit_busy & owner_oh);

    smaesh_arb_prio_sel #(
        .NCH (NCH),
        .IW  (IW)
    ) u_prio_sel (
        .eligible  (eligible),
        .boosted   (boosted),
        .grant_oh  (win_oh),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        err_d   = err_q;
        for (int i = 0; i < int'(NCH); i++) age_d[i] = age_q[i];
        case (state_q)
            StIdle: begin
                if (win_any) begin
                    state_d = StStart;
                    owner_d = win_idx;
                    cnt_d   = TO_W'(1);   // counts START cycles, including the first
                    start_d = 1'b1;
                    for (int i = 0; i < int'(NCH); i++) begin
                        if (win_oh[i]) begin
                            age_d[i] = '0;
                        end else if (eligible[i] && (age_q[i] != AGE_SAT)) begin
                            age_d[i] = age_q[i] + 1'b1;
                        end
                    end
                end
            end
            StStart: begin
                if (owner_busy) begin
                    state_d = StBusy;
                end else if (cnt_q == TO_W'(START_TO)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBusy: begin
                if (!owner_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            prev_busy_q <= '0;
            for (int i = 0; i < int'(NCH); i++) age_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            err_q       <= err_d;
            prev_busy_q <= unit_busy;
            for (int i = 0; i < int'(NCH); i++) age_q[i] <= age_d[i];
        end
    end

    assign arb_busy    = (state_q != StIdle);
    assign owner_idx   = arb_busy ? owner_q : '0;
    assign err_timeout = err_q;
    assign unit_start  = start_q ? owner_oh : '0;
    assign unit_valid  = arb_busy ? (in_valid & owner_oh) : '0;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (arb_busy && owner_oh[i]) begin
                in_ready[i] = READY_PULSE[i] ? (unit_busy[i] & ~prev_busy_q[i])
                                             : unit_in_ready[i];
            end
        end
    end

endmodule

// File: tb/tb_smaesh_stream_arbiter.sv
// Self-checking bench for smaesh_stream_arbiter: grant order is scoreboarded against unit_start.
module tb_smaesh_stream_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [2:0] unit_in_ready;
    logic [2:0] unit_busy;
    logic       prng_seeded;
    logic [2:0] unit_start;
    logic [2:0] unit_valid;
    logic [1:0] owner_idx;
    logic       arb_busy;
    logic       err_timeout;

    int         n_tests;
    int         n_fail;
    logic [2:0] sb[$];

    smaesh_stream_arbiter u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .unit_in_ready (unit_in_ready),
        .unit_busy     (unit_busy),
        .prng_seeded   (prng_seeded),
        .unit_start    (unit_start),
        .unit_valid    (unit_valid),
        .owner_idx     (owner_idx),
        .arb_busy      (arb_busy),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 0);
        check({tag, "_start"}, 32'(unit_start), 0);
        check({tag, "_uvalid"}, 32'(unit_valid), 0);
        check({tag, "_owner"}, 32'(owner_idx), 0);
        check({tag, "_busy"}, 32'(arb_busy), 0);
        check({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        in_valid      = '0;
        unit_in_ready = '0;
        unit_busy     = '0;
        prng_seeded   = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // One full grant cycle from IDLE: grant, unit goes busy, unit releases, back in IDLE.
    task automatic round(input logic [2:0] exp_oh, input logic [1:0] exp_idx);
        sb.push_back(exp_oh);
        tick(1);
        check("round_owner", 32'(owner_idx), 32'(exp_idx));
        unit_busy = exp_oh;
        tick(1);
        unit_busy = '0;
        tick(1);
    endtask

    // Every start pulse must match the next expected grant.
    always @(negedge clk) begin
        if (!rst && (|unit_start)) begin
            if (sb.size() == 0) begin
                check("start_unexpected", 32'(unit_start), 0);
            end else begin
                check("start_oh", 32'(unit_start), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        int pulses;
        int busy_cycles;
        n_tests = 0;
        n_fail  = 0;

        do_reset();
        check_all_zero("reset");

        // Seed gating, then key owner with pass-through ready.
        in_valid      = 3'b110;
        unit_in_ready = 3'b111;
        tick(3);
        check("unseeded_busy", 32'(arb_busy), 0);
        check("unseeded_ready", 32'(in_ready), 0);
        sb.push_back(3'b010);
        prng_seeded = 1'b1;
        tick(1);
        check("key_owner", 32'(owner_idx), 1);
        check("key_uvalid", 32'(unit_valid), 32'(3'b010));
        check("key_ready_start", 32'(in_ready), 32'(3'b010));
        unit_busy = 3'b010;
        tick(1);
        unit_in_ready = 3'b100;
        #1 check("key_busy_ready_lo", 32'(in_ready), 0);
        unit_in_ready = 3'b110;
        #1 check("key_busy_ready_hi", 32'(in_ready), 32'(3'b010));
        prng_seeded = 1'b0;
        tick(2);
        check("seed_drop_no_abort", 32'(arb_busy), 1);
        check("seed_drop_owner", 32'(owner_idx), 1);
        in_valid  = '0;
        unit_busy = '0;
        tick(1);
        check("key_release", 32'(arb_busy), 0);

        // All valid and seeded: seed stream first with pulse ready, then key.
        do_reset();
        in_valid    = 3'b111;
        prng_seeded = 1'b1;
        sb.push_back(3'b001);
        tick(1);
        check("seed_owner", 32'(owner_idx), 0);
        check("seed_ready_prebusy", 32'(in_ready), 0);
        unit_busy = 3'b001;
        pulses    = 0;
        #1 if (in_ready[0]) pulses++;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            in_valid = 3'b110;
            #1 if (in_ready[0]) pulses++;
        end
        check("seed_pulse_count", 32'(pulses), 1);
        sb.push_back(3'b010);
        unit_busy = '0;
        tick(1);
        check("bubble_idle", 32'(arb_busy), 0);
        tick(1);
        check("next_owner_key", 32'(owner_idx), 1);
        unit_busy = 3'b010;
        tick(1);
        check("key_busy", 32'(arb_busy), 1);
        rst = 1'b1;
        tick(1);
        check_all_zero("midrst");
        do_reset();

        // Aging: stream 0 keeps winning until stream 2 has lost four times.
        in_valid    = 3'b101;
        prng_seeded = 1'b1;
        for (int i = 0; i < 4; i++) round(3'b001, 2'd0);
        round(3'b100, 2'd2);
        round(3'b001, 2'd0);
        in_valid = '0;
        tick(2);

        // Start timeout: the granted unit never reports busy.
        do_reset();
        in_valid = 3'b001;
        sb.push_back(3'b001);
        tick(1);
        in_valid    = '0;
        busy_cycles = 1;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (arb_busy) busy_cycles++;
        end
        check("to_start_cycles", 32'(busy_cycles), 15);
        check("to_err_early", 32'(err_timeout), 0);
        tick(1);
        check("to_idle", 32'(arb_busy), 0);
        check("to_err_set", 32'(err_timeout), 1);
        tick(3);
        check("to_err_sticky", 32'(err_timeout), 1);
        do_reset();
        check("to_err_cleared", 32'(err_timeout), 0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
